// File: rtl/mux2_arb_pkg.sv
// Shared types for the two-requester mux arbiter.
// State encoding and default datapath width.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/mux2_arbiter_if.sv
// Producer/consumer bundle around the mux arbiter.
// master = producers + consumer side, slave = arbiter.
interface mux2_arbiter_if
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] d0_in;
  logic [WIDTH-1:0] d1_in;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] y_out;
  logic             y_valid;
  logic             busy;

  modport master (
    output req0,
    output req1,
    output d0_in,
    output d1_in,
    input  gnt0,
    input  gnt1,
    input  sel,
    input  y_out,
    input  y_valid,
    input  busy
  );

  modport slave (
    input  req0,
    input  req1,
    input  d0_in,
    input  d1_in,
    output gnt0,
    output gnt1,
    output sel,
    output y_out,
    output y_valid,
    output busy
  );

endinterface

// File: rtl/mux2.sv
// Plain 2:1 data mux shared by the arbiter.
// s=0 selects d0, s=1 selects d1.
module mux2 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin owner FSM in front of mux2 with registered output.
// MUX2_ARB_BURST_LIMIT_EN caps a grant at MAX_BURST transfers.
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef MUX2_ARB_BURST_LIMIT_EN
  ,
  parameter int MAX_BURST = 4
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  mux2_arbiter_if.slave   bus
);

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic             ptr_q;
  logic             ptr_d;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_d;
  logic             yv_q;
  logic             yv_d;
  logic             sel;
  logic             xfer;
  logic             limit_hit;
  logic [WIDTH-1:0] mux_y;

  assign sel = (state_q == OWN1);

  mux2 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .d0(bus.d0_in),
    .d1(bus.d1_in),
    .s (sel),
    .y (mux_y)
  );

`ifdef MUX2_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign limit_hit = (cnt_q == CW'(MAX_BURST - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (xfer) begin
      cnt_d = limit_hit ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  // ptr_q=0 favours req0 when both ask from IDLE
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    y_d     = y_q;
    yv_d    = 1'b0;
    xfer    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || !ptr_q)) begin
          state_d = OWN0;
        end else if (bus.req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (bus.req0) begin
          xfer = 1'b1;
          if (limit_hit && bus.req1) begin
            state_d = OWN1;
          end
        end else begin
          state_d = bus.req1 ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (bus.req1) begin
          xfer = 1'b1;
          if (limit_hit && bus.req0) begin
            state_d = OWN0;
          end
        end else begin
          state_d = bus.req0 ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      y_d  = mux_y;
      yv_d = 1'b1;
    end
    if (state_d != state_q) begin
      if (state_d == OWN0) begin
        ptr_d = 1'b1;
      end else if (state_d == OWN1) begin
        ptr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      y_q     <= '0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

  assign bus.gnt0    = (state_q == OWN0);
  assign bus.gnt1    = (state_q == OWN1);
  assign bus.sel     = sel;
  assign bus.y_out   = y_q;
  assign bus.y_valid = yv_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter.
// Build with +define+MUX2_ARB_BURST_LIMIT_EN for the limit case.
module tb_mux2_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  mux2_arbiter_if #(.WIDTH(4)) bus ();

  mux2_arbiter #(
    .WIDTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".gnt0"}, 8'(bus.gnt0), 8'h0);
    chk({tag, ".gnt1"}, 8'(bus.gnt1), 8'h0);
    chk({tag, ".sel"}, 8'(bus.sel), 8'h0);
    chk({tag, ".yv"}, 8'(bus.y_valid), 8'h0);
    chk({tag, ".busy"}, 8'(bus.busy), 8'h0);
  endtask

  task automatic do_reset();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst_n     = 1'b1;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.d0_in = 4'h0;
    bus.d1_in = 4'h0;
    #1;
    rst_n = 1'b0;

    // reset held while requests toggle
    bus.req0 = 1'b1;
    step();
    bus.req1 = 1'b1;
    step();
    chk_idle("rst");
    chk("rst.y", 8'(bus.y_out), 8'h0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk_idle("idle");

    // single burst from requester 0
    bus.req0  = 1'b1;
    bus.d0_in = 4'hA;
    step();
    chk("b.gnt0", 8'(bus.gnt0), 8'h1);
    chk("b.busy", 8'(bus.busy), 8'h1);
    chk("b.yv0", 8'(bus.y_valid), 8'h0);
    step();
    chk("b.yA", 8'(bus.y_out), 8'hA);
    chk("b.yvA", 8'(bus.y_valid), 8'h1);
    bus.d0_in = 4'h5;
    step();
    chk("b.y5", 8'(bus.y_out), 8'h5);
    chk("b.sel", 8'(bus.sel), 8'h0);
    bus.d0_in = 4'hF;
    step();
    chk("b.yF", 8'(bus.y_out), 8'hF);
    chk("b.yvF", 8'(bus.y_valid), 8'h1);
    bus.req0 = 1'b0;
    step();
    chk_idle("b.end");
    chk("b.yhold", 8'(bus.y_out), 8'hF);

    // contention from idle, pointer freshly reset
    do_reset();
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.d0_in = 4'h7;
    bus.d1_in = 4'h3;
    step();
    chk("c.gnt0", 8'(bus.gnt0), 8'h1);
    chk("c.gnt1", 8'(bus.gnt1), 8'h0);
    step();
    chk("c.y7", 8'(bus.y_out), 8'h7);
    bus.req0 = 1'b0;
    step();
    chk("c.sw1", 8'(bus.gnt1), 8'h1);
    chk("c.sel", 8'(bus.sel), 8'h1);
    chk("c.busy", 8'(bus.busy), 8'h1);
    chk("c.yv", 8'(bus.y_valid), 8'h0);
    step();
    chk("c.y3", 8'(bus.y_out), 8'h3);
    chk("c.yv3", 8'(bus.y_valid), 8'h1);
    bus.req1 = 1'b0;
    step();
    chk_idle("c.end");

    // fairness: 8 two-transfer bursts with both requesting
    do_reset();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    step();
    for (int b = 0; b < 8; b++) begin
      logic       o;
      logic [3:0] dv;
      o  = b[0];
      dv = o ? ~4'(b) : 4'(b);
      chk($sformatf("f%0d.gnt0", b), 8'(bus.gnt0), 8'(!o));
      chk($sformatf("f%0d.gnt1", b), 8'(bus.gnt1), 8'(o));
      chk($sformatf("f%0d.mutex", b),
          8'(bus.gnt0 & bus.gnt1), 8'h0);
      bus.req0  = 1'b1;
      bus.req1  = 1'b1;
      bus.d0_in = 4'(b);
      bus.d1_in = ~4'(b);
      for (int k = 0; k < 2; k++) begin
        step();
        chk($sformatf("f%0d.y%0d", b, k), 8'(bus.y_out), 8'(dv));
        chk($sformatf("f%0d.v%0d", b, k), 8'(bus.y_valid), 8'h1);
      end
      if (o) bus.req1 = 1'b0;
      else bus.req0 = 1'b0;
      step();
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
    step();
    chk_idle("f.end");

    // asynchronous reset during an OWN1 burst
    do_reset();
    bus.req1  = 1'b1;
    bus.d1_in = 4'hC;
    step();
    chk("a.gnt1", 8'(bus.gnt1), 8'h1);
    step();
    chk("a.yC", 8'(bus.y_out), 8'hC);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("a.rst");
    chk("a.y0", 8'(bus.y_out), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("a.regnt", 8'(bus.gnt1), 8'h1);
    chk("a.sel", 8'(bus.sel), 8'h1);
    bus.req1 = 1'b0;
    step();

    // continuous contention: burst limit vs. held grant
    do_reset();
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.d0_in = 4'hA;
    bus.d1_in = 4'h5;
    step();
    for (int k = 0; k < 16; k++) begin
      logic [3:0] ey;
      step();
`ifdef MUX2_ARB_BURST_LIMIT_EN
      ey = ((k / 4) % 2 == 0) ? 4'hA : 4'h5;
`else
      ey = 4'hA;
      chk($sformatf("l%0d.gnt0", k), 8'(bus.gnt0), 8'h1);
`endif
      chk($sformatf("l%0d.y", k), 8'(bus.y_out), 8'(ey));
      chk($sformatf("l%0d.v", k), 8'(bus.y_valid), 8'h1);
      chk($sformatf("l%0d.mutex", k),
          8'(bus.gnt0 & bus.gnt1), 8'h0);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
    step();
    chk_idle("l.end");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
Round-robin arbiter that shares the 2:1 mux datapath (mux2) between two requesters.
- Each requester raises req and holds it for a burst; the arbiter grants one owner at a time and drives the mux select.
- The selected data is registered into a single output with a valid flag.
- Sits between two producer blocks and one downstream consumer of y.

Parameters:
WIDTH, 4, data width of d0_in/d1_in/y_out (matches mux2 data width)
MAX_BURST, 4, max consecutive transfers per grant; only used when MUX2_ARB_BURST_LIMIT_EN is defined; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 wants the datapath; held high for the whole burst
req1  input  1  requester 1 wants the datapath
d0_in  input  WIDTH  requester 0 data (mux d0)
d1_in  input  WIDTH  requester 1 data (mux d1)
gnt0  output  1  requester 0 owns the datapath
gnt1  output  1  requester 1 owns the datapath
sel  output  1  mux select: 0 = d0, 1 = d1
y_out  output  WIDTH  registered selected data
y_valid  output  1  y_out holds a transfer completed at the last edge
busy  output  1  FSM is not in IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; gnt0=gnt1=0; sel=0; y_out=0; y_valid=0; busy=0; round-robin pointer favours requester 0. Reset mid-burst aborts immediately; no partial-transfer state survives.
- FSM states:
  - IDLE: no owner.
  - OWN0: gnt0=1, sel=0.
  - OWN1: gnt1=1, sel=1.
  - gnt0 and gnt1 are never both 1. busy=1 in OWN0/OWN1.
- IDLE transitions:
  - Only req0 high -> OWN0. Only req1 high -> OWN1.
  - Both high -> the requester favoured by the pointer.
  - Neither high -> stay in IDLE.
- Grant latency: req sampled at edge N -> gnt high after edge N. This is a registered grant with no combinational req-to-gnt path.
- Transfer: at each edge where the owner has req=1 and gnt=1, y_out <= mux output and y_valid <= 1. Otherwise y_valid <= 0 and y_out holds its value.
  - Data-to-y_out latency is 1 cycle.
- Burst end: when the owner samples req=0:
  - the other requester is high -> switch directly to the other OWNx (no IDLE bubble);
  - otherwise -> IDLE.
- Pointer update: on every grant, the pointer moves to favour the non-granted requester. Two requesters held high therefore alternate ownership at each burst end.
- Non-owner req: ignored until a switch decision. The non-owner's data is never sampled.
- sel in IDLE returns to 0.

Optional Feature:
MUX2_ARB_BURST_LIMIT_EN
- Defined:
  - An internal transfer counter (width $clog2(MAX_BURST+1)) counts transfers in the current grant.
  - After MAX_BURST transfers, if the other requester is high, the grant is forced to the other requester at that edge. The old owner sees gnt drop and must keep req high to be re-granted later.
  - If the other requester is low, the counter resets and the owner keeps the grant.
  - The counter clears on every grant change and on reset.
- Undefined: no counter; the owner keeps the grant until it drops req.

Decomposition:
- Package mux2_arb_pkg: typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t; localparam DEFAULT_WIDTH = 4.
- Sub-module: instantiate the existing mux2 (d0=d0_in, d1=d1_in, s=sel) for data selection. The arbiter adds only the FSM, pointer, optional counter and output register.

Test Plan:
- Reset: hold rst_n=0, toggle req0/req1 -> all outputs 0, busy=0. Release, all req low -> stays IDLE.
- Single burst: req0=1 for 3 cycles with d0_in=4'hA,4'h5,4'hF -> gnt0 one cycle after req0; y_out=A,5,F on consecutive cycles with y_valid=1; IDLE after req0 drops; sel stays 0.
- Contention from idle: req0=req1=1 at the same edge, d1_in=4'h3 -> gnt0 first. When req0 drops, gnt1 on the next cycle with no IDLE cycle, sel=1, y_out=3.
- Fairness: both req held high with 2-cycle bursts for 8 bursts -> ownership alternates 0,1,0,1…; gnt0&gnt1 never both 1.
- Async reset mid-burst: rst_n low between edges during OWN1 -> gnt1, sel, y_valid, y_out go 0 immediately. After release with req1 high -> re-granted after one edge.
- Burst limit (macro defined, MAX_BURST=4): req0 and req1 held high continuously -> exactly 4 y_valid transfers from d0, then gnt1 takes over for 4, alternating. Macro undefined -> gnt0 held indefinitely.
